// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: instruction memory filled through a load session and read
// through a registered fetch port with one cycle of latency.
// Optional feature macro: IMEM_PARITY_EN adds one even-parity bit per stored word
// and a parity_err output that is checked on every fetch.
//
// state | meaning
// IDLE  | fetches served; load_en starts a new session
// LOAD  | load_ready=1, each valid word written at wr_ptr
// DONE  | single-cycle load_done pulse, then back to IDLE
module instr_mem_loadable #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instruction,
  output logic              fetch_valid,
  output logic              busy
`ifdef IMEM_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              wr_en;
  logic              fetch_ok;

  // Contents survive reset; only power-up zeroes them.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  assign fetch_ok = (state == ST_IDLE) && fetch_req;

  // Next-state and handshake outputs; a write at the last address ends the session.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    load_done  = 1'b0;
    busy       = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (!load_en) begin
          state_nxt = ST_DONE;
        end else if (load_valid) begin
          wr_en = 1'b1;
          if (&wr_ptr) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        load_done = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, write pointer and word counter; the pointer saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      load_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && load_en) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (wr_en) begin
        load_count <= load_count + (ADDR_W+1)'(1);
        if (!(&wr_ptr)) wr_ptr <= wr_ptr + ADDR_W'(1);
      end
    end
  end

  // Memory write port; reset blocks a write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr] <= load_data;
  end

  // Registered fetch port; instruction holds when no fetch is served.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_valid <= 1'b0;
      instruction <= '0;
    end else if (fetch_ok) begin
      fetch_valid <= 1'b1;
      instruction <= mem[pc];
    end else begin
      fetch_valid <= 1'b0;
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH] = '{default: 1'b0};

  // Parity bit is written alongside its data word.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) par_mem[wr_ptr] <= ^load_data;
  end

  // Parity error qualifies the same cycle as fetch_valid and is low otherwise.
  always_ff @(posedge clk) begin
    if (rst)           parity_err <= 1'b0;
    else if (fetch_ok) parity_err <= (^mem[pc]) ^ par_mem[pc];
    else               parity_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: fixed vectors from the loader/fetch scenarios
// plus randomized load sessions checked against an array model of the memory.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, load_valid;
  logic [31:0] load_data;
  logic        load_ready, load_done;
  logic [5:0]  load_count;
  logic        fetch_req;
  logic [4:0]  pc;
  logic [31:0] instruction;
  logic        fetch_valid, busy;
`ifdef IMEM_PARITY_EN
  logic        parity_err;
`endif

  instr_mem_loadable #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .load_en(load_en), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .load_count(load_count),
    .fetch_req(fetch_req), .pc(pc), .instruction(instruction),
    .fetch_valid(fetch_valid), .busy(busy)
`ifdef IMEM_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] model [32];
  logic [31:0] last_instr;

  typedef struct {
    logic [4:0]  pc;
    logic [31:0] exp;
  } fvec_t;
  fvec_t vec [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fetch_check(input logic [4:0] a, input string name);
    fetch_req = 1'b1;
    pc = a;
    tick();
    fetch_req = 1'b0;
    check({name, " valid"}, {31'd0, fetch_valid}, 32'd1);
    check(name, instruction, model[a]);
    last_instr = model[a];
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b1; load_en = 1'b0; load_valid = 1'b0; load_data = '0;
    fetch_req = 1'b0; pc = '0;
    tick(); tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst load_ready", {31'd0, load_ready}, 32'd0);
    check("rst load_done", {31'd0, load_done}, 32'd0);
    check("rst load_count", {26'd0, load_count}, 32'd0);
    check("rst fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst instruction", instruction, 32'd0);
    rst = 1'b0;

    // Three-word session.
    load_en = 1'b1;
    tick();
    check("load ready", {31'd0, load_ready}, 32'd1);
    check("load busy", {31'd0, busy}, 32'd1);
    model[0] = 32'hC00A000A; model[1] = 32'hC01E000F; model[2] = 32'h53F26000;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = model[i];
      tick();
    end
    load_valid = 1'b0; load_en = 1'b0;
    tick();
    check("3w load_done", {31'd0, load_done}, 32'd1);
    check("3w load_ready in DONE", {31'd0, load_ready}, 32'd0);
    check("3w load_count", {26'd0, load_count}, 32'd3);
    tick();
    check("3w busy after DONE", {31'd0, busy}, 32'd0);
    check("3w done pulse ends", {31'd0, load_done}, 32'd0);

    // Back-to-back fetches from a vector table.
    vec[0] = '{pc: 5'd2, exp: 32'h53F26000};
    vec[1] = '{pc: 5'd0, exp: 32'hC00A000A};
    vec[2] = '{pc: 5'd5, exp: 32'h00000000};
    vec[3] = '{pc: 5'd1, exp: 32'hC01E000F};
    for (int i = 0; i < 4; i++) begin
      fetch_req = 1'b1; pc = vec[i].pc;
      tick();
      check($sformatf("vec%0d valid", i), {31'd0, fetch_valid}, 32'd1);
      check($sformatf("vec%0d instr", i), instruction, vec[i].exp);
    end
    fetch_req = 1'b0;
    last_instr = 32'hC01E000F;
    tick();
    check("idle fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("idle instr hold", instruction, last_instr);

    // Fetch blocked during LOAD, then reset part-way through a session.
    load_en = 1'b1;
    tick();
    fetch_req = 1'b1; pc = 5'd1;
    tick();
    fetch_req = 1'b0;
    check("load fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("load instr hold", instruction, last_instr);
    load_valid = 1'b1; load_data = 32'h11111111; tick();
    load_data = 32'h22222222; tick();
    check("partial load_count", {26'd0, load_count}, 32'd2);
    model[0] = 32'h11111111; model[1] = 32'h22222222;
    load_data = 32'h33333333; rst = 1'b1;
    tick();
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort load_done", {31'd0, load_done}, 32'd0);
    check("abort load_count", {26'd0, load_count}, 32'd0);
    check("abort instr", instruction, 32'd0);
    rst = 1'b0; load_en = 1'b0; load_valid = 1'b0;
    tick();
    check("abort no pulse", {31'd0, load_done}, 32'd0);
    fetch_check(5'd0, "abort mem0");
    fetch_check(5'd1, "abort mem1");
    fetch_check(5'd2, "abort mem2 kept");

    // Full 32-word load with load_en and load_valid held high.
    load_en = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1; load_data = $urandom;
      model[i] = load_data;
      tick();
      check($sformatf("full count%0d", i), {26'd0, load_count}, i + 1);
      check($sformatf("full done%0d", i), {31'd0, load_done}, (i == 31) ? 32'd1 : 32'd0);
    end
    load_data = 32'hDEADBEEF;
    tick();
    check("full DONE one cycle", {31'd0, load_done}, 32'd0);
    check("full busy after", {31'd0, busy}, 32'd0);
    load_en = 1'b0; load_valid = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) fetch_check(5'(a), $sformatf("full mem%0d", a));

`ifdef IMEM_PARITY_EN
    dut.mem[4] = dut.mem[4] ^ 32'h1;
    fetch_req = 1'b1; pc = 5'd4;
    tick();
    check("par err valid", {31'd0, fetch_valid}, 32'd1);
    check("par err pc4", {31'd0, parity_err}, 32'd1);
    pc = 5'd3;
    tick();
    fetch_req = 1'b0;
    check("par ok pc3", {31'd0, parity_err}, 32'd0);
    last_instr = model[3];
    tick();
    check("par idle", {31'd0, parity_err}, 32'd0);
`endif

    // Randomized sessions against the array model.
    for (int s = 0; s < 6; s++) begin
      int n, len;
      n = 0;
      len = $urandom_range(1, 12);
      load_en = 1'b1;
      tick();
      for (int k = 0; k < len; k++) begin
        load_valid = 1'($urandom_range(0, 1));
        load_data = $urandom;
        if (load_valid) begin
          model[n] = load_data;
          n++;
        end
        tick();
      end
      load_valid = 1'b0; load_en = 1'b0;
      tick();
      check($sformatf("rnd%0d done", s), {31'd0, load_done}, 32'd1);
      check($sformatf("rnd%0d count", s), {26'd0, load_count}, n);
      tick();
      for (int f = 0; f < 16; f++) begin
        logic req;
        req = 1'($urandom_range(0, 1));
        fetch_req = req;
        pc = 5'($urandom_range(0, 31));
        if (req) last_instr = model[pc];
        tick();
        check($sformatf("rnd%0d valid%0d", s, f), {31'd0, fetch_valid}, {31'd0, req});
        check($sformatf("rnd%0d instr%0d", s, f), instruction, last_instr);
      end
      fetch_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_mem_loadable.md
INSTR_MEM_LOADABLE -- requirements
Module: instr_mem_loadable

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: fetch/load address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port load_en  input  1: request to enter or stay in program-load mode.
REQ-006 SHALL have port load_valid  input  1: load_data holds a valid word.
REQ-007 SHALL have port load_data  input  DATA_W: program word to store.
REQ-008 SHALL have port load_ready  output  1: the block accepts a load word this cycle.
REQ-009 SHALL have port load_done  output  1: one-cycle pulse marking the end of a load session.
REQ-010 SHALL have port load_count  output  ADDR_W+1: number of words written in the current or last session.
REQ-011 SHALL have port fetch_req  input  1: fetch request; pc is sampled in the same cycle.
REQ-012 SHALL have port pc  input  ADDR_W: fetch word address.
REQ-013 SHALL have port instruction  output  DATA_W: registered fetch data.
REQ-014 SHALL have port fetch_valid  output  1: instruction is valid this cycle.
REQ-015 SHALL have port busy  output  1: high while state is LOAD or DONE.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD and DONE.
REQ-017 IDLE -> LOAD when load_en=1; load_count is cleared to 0 and the write pointer is set to 0 on this transition.
REQ-018 In LOAD, load_ready SHALL be 1; every cycle with load_valid=1 writes load_data to mem[wr_ptr], increments wr_ptr and increments load_count.
REQ-019 LOAD -> DONE when load_en=0, or when the word written is at address DEPTH-1; the write pointer SHALL NOT wrap, and no write occurs in the cycle load_en is 0.
REQ-020 DONE SHALL last exactly one cycle with load_done=1 and load_ready=0, then go to IDLE, even if load_en=1.
REQ-021 In IDLE, fetch_req=1 at edge N SHALL give instruction=mem[pc sampled at N] and fetch_valid=1 after edge N+1 (1-cycle latency), with back-to-back fetches at full rate.
REQ-022 fetch_req during LOAD or DONE SHALL be ignored: fetch_valid=0 and instruction holds its value.
REQ-023 When no fetch is served, fetch_valid SHALL be 0 and instruction SHALL hold its last value.
REQ-024 A fetch of the address written in the same cycle is not possible, because fetches are blocked in LOAD.
REQ-025 Locations not written since power-up SHALL read as 0; memory SHALL be zero-initialised at time 0.

Reset
REQ-026 When rst=1 at a clock edge, the following SHALL take effect: state=IDLE, load_ready=0, load_done=0, load_count=0, fetch_valid=0, instruction=0, busy=0.
REQ-027 Reset SHALL NOT clear memory contents; reset in the middle of a load keeps the words already written and aborts the session without a load_done pulse.
REQ-028 Reset SHALL take priority over load_en, load_valid and fetch_req in the same cycle.

Configuration
REQ-029 Macro IMEM_PARITY_EN, when defined, SHALL add output parity_err (1 bit) and store one even-parity bit per word on every load write.
REQ-030 With IMEM_PARITY_EN defined, parity_err SHALL be valid together with fetch_valid and SHALL be 1 when the stored parity does not match the fetched data; it SHALL be 0 otherwise and 0 after reset.
REQ-031 Without IMEM_PARITY_EN, the parity_err port and the parity storage SHALL NOT exist; behaviour is otherwise identical.

Verification
REQ-032 Stimulus: rst, then load_en=1 and 3 words 0xC00A000A, 0xC01E000F, 0x53F26000, then load_en=0. Required: load_done pulse one cycle after load_en falls, load_count=3, busy=0 after DONE.
REQ-033 Stimulus: after REQ-032, fetch_req with pc=2, then pc=0 back-to-back. Required: instruction=0x53F26000 then 0xC00A000A, fetch_valid=1 on 2 consecutive cycles, each 1 cycle after its request.
REQ-034 Stimulus: with ADDR_W=5, load 32 words, load_valid held high and load_en held high. Required: transition to DONE after the write to address 31, load_count=32, no wrap, and the 33rd word is not written (mem[0] unchanged).
REQ-035 Stimulus: fetch_req=1, pc=1 during LOAD. Required: fetch_valid=0 and instruction unchanged. Stimulus: rst asserted after 2 of 4 words. Required: state IDLE, no load_done, and mem[0..1] readable with the new values.
REQ-036 With IMEM_PARITY_EN defined, stimulus: force one stored bit flip at address 4, then fetch pc=4. Required: parity_err=1 with fetch_valid=1; a fetch of pc=3 gives parity_err=0.
